// File: rtl/bcd_ctrl_pkg.sv
// Shared types and constants for the cascaded BCD counter sequencer.
package bcd_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;
    localparam logic [1:0] OP_ZERO  = 2'b11;

    localparam int unsigned DIGIT_W   = 4;
    localparam logic [3:0]  DIGIT_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// One mod-10 counter digit; q_inc is the incremented value before the sync zero,
// so the parent can compare it against a terminal value without a loop.
module bcd_digit
    import bcd_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               clear,
    input  logic               inc,
    input  logic               zero,
    output logic [DIGIT_W-1:0] q,
    output logic [DIGIT_W-1:0] q_inc,
    output logic               carry
);

    logic [DIGIT_W-1:0] r_q;

    always_comb begin
        q_inc = r_q;
        if (inc) begin
            q_inc = (r_q == DIGIT_MAX) ? '0 : r_q + 1'b1;
        end
        carry = inc && (r_q == DIGIT_MAX);
        q     = r_q;
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_q <= '0;
        end else if (zero) begin
            r_q <= '0;
        end else begin
            r_q <= q_inc;
        end
    end

endmodule

// File: rtl/bcd_count_ctrl.sv
// Start/stop/zero sequencer for a chain of BCD digits with prescaler, terminal value and lap capture.
// Optional macro BCD_CNT_AUTORELOAD_EN: terminal match reloads zero and keeps running.
module bcd_count_ctrl
    import bcd_ctrl_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 10
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [4*DIGITS-1:0]   limit,
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  done,
    output logic                  wrap,
    input  logic                  lap_req,
    output logic                  snap_valid,
    input  logic                  snap_ready,
    output logic [4*DIGITS-1:0]   snap_data,
    output logic                  lap_drop
);

    localparam int unsigned CW = DIGIT_W * DIGITS;
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
`ifdef BCD_CNT_AUTORELOAD_EN
    localparam bit AUTORELOAD = 1'b1;
`else
    localparam bit AUTORELOAD = 1'b0;
`endif

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_presc;
    logic            r_cmd_ready;
    logic            r_wrap;
    logic            r_done_pulse;
    logic            r_snap_valid;
    logic [CW-1:0]   r_snap_data;
    logic            r_lap_drop;

    logic            w_acc, w_start, w_stop, w_zero;
    logic            w_tick_due, w_tick, w_match, w_clr_cnt, w_snap_acc;
    logic [DIGITS:0] w_inc;
    logic [CW-1:0]   w_cnt, w_cnt_inc;

    assign w_acc      = cmd_valid && r_cmd_ready;
    assign w_start    = w_acc && (cmd_op == OP_START);
    assign w_stop     = w_acc && (cmd_op == OP_STOP);
    assign w_zero     = w_acc && (cmd_op == OP_ZERO);
    assign w_tick_due = (r_state == RUN) && (r_presc == PW'(PRESCALE - 1));
    // A same-cycle STOP or ZERO swallows the tick.
    assign w_tick     = w_tick_due && !w_stop && !w_zero;
    assign w_match    = w_tick && (w_cnt_inc == limit);
    assign w_clr_cnt  = w_zero || (AUTORELOAD && w_match);
    assign w_snap_acc = r_snap_valid && snap_ready;
    assign w_inc[0]   = w_tick;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk   (clk),
            .clear (clear),
            .inc   (w_inc[g]),
            .zero  (w_clr_cnt),
            .q     (w_cnt[g*DIGIT_W +: DIGIT_W]),
            .q_inc (w_cnt_inc[g*DIGIT_W +: DIGIT_W]),
            .carry (w_inc[g+1])
        );
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_zero) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_start) w_state_nxt = RUN;
                RUN: begin
                    if (w_stop)                      w_state_nxt = PAUSE;
                    else if (w_match && !AUTORELOAD) w_state_nxt = DONE;
                end
                PAUSE:   if (w_start) w_state_nxt = RUN;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        running    = (r_state == RUN);
        done       = AUTORELOAD ? r_done_pulse : (r_state == DONE);
        cmd_ready  = r_cmd_ready;
        wrap       = r_wrap;
        count      = w_cnt;
        snap_valid = r_snap_valid;
        snap_data  = r_snap_data;
        lap_drop   = r_lap_drop;
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_presc      <= '0;
            r_cmd_ready  <= 1'b1;
            r_wrap       <= 1'b0;
            r_done_pulse <= 1'b0;
            r_snap_valid <= 1'b0;
            r_snap_data  <= '0;
            r_lap_drop   <= 1'b0;
        end else begin
            r_cmd_ready  <= !w_acc;
            r_wrap       <= w_inc[DIGITS];
            r_done_pulse <= w_match;
            r_lap_drop   <= lap_req && r_snap_valid && !snap_ready;

            // Prescaler holds outside RUN so a paused partial tick survives.
            if (w_zero) begin
                r_presc <= '0;
            end else if ((r_state == RUN) && !w_stop) begin
                r_presc <= w_tick_due ? '0 : r_presc + 1'b1;
            end

            if (lap_req && (!r_snap_valid || snap_ready)) begin
                r_snap_valid <= 1'b1;
                r_snap_data  <= w_cnt;
            end else if (w_snap_acc) begin
                r_snap_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Scoreboard bench for bcd_count_ctrl (DIGITS=2, PRESCALE=2) against an integer-arithmetic model.
module tb_bcd_count_ctrl;

    localparam int DIGITS   = 2;
    localparam int PRESCALE = 2;
    localparam int W        = 4 * DIGITS;
    localparam int CMOD     = 100;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

    logic         clk = 1'b0;
    logic         clear;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'b00;
    logic [W-1:0] limit = '0;
    logic [W-1:0] count;
    logic         running, done, wrap;
    logic         lap_req = 1'b0;
    logic         snap_valid;
    logic         snap_ready = 1'b0;
    logic [W-1:0] snap_data;
    logic         lap_drop;

    bcd_count_ctrl #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
        .clk        (clk),
        .clear      (clear),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .limit      (limit),
        .count      (count),
        .running    (running),
        .done       (done),
        .wrap       (wrap),
        .lap_req    (lap_req),
        .snap_valid (snap_valid),
        .snap_ready (snap_ready),
        .snap_data  (snap_data),
        .lap_drop   (lap_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         ready;
        logic [W-1:0] cnt;
        logic         run;
        logic         dn;
        logic         wr;
        logic         sv;
        logic [W-1:0] sd;
        logic         drop;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    int         m_cnt, m_pre, m_state;
    bit         m_ready, m_wrap, m_done_p, m_sv, m_drop;
    logic [W-1:0] m_sd;
    logic [W-1:0] cur_lim;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_cnt = 0; m_pre = 0; m_state = S_IDLE;
        m_ready = 1; m_wrap = 0; m_done_p = 0; m_sv = 0; m_drop = 0; m_sd = '0;
    endtask

    task automatic model_edge(input bit v, input bit [1:0] op, input bit lap, input bit sr,
                              input logic [W-1:0] lim);
        bit acc;
        int st0, c0;
        bit sv0;
        acc = v && m_ready;
        st0 = m_state; c0 = m_cnt; sv0 = m_sv;
        m_wrap = 0; m_done_p = 0;
        if (acc && op == 2'd3) begin
            m_cnt = 0; m_pre = 0; m_state = S_IDLE;
        end else if (acc && op == 2'd2 && st0 == S_RUN) begin
            m_state = S_PAUSE;
        end else begin
            if (st0 == S_RUN) begin
                if (m_pre == PRESCALE - 1) begin
                    m_pre  = 0;
                    m_wrap = (c0 == CMOD - 1);
                    m_cnt  = (c0 + 1) % CMOD;
                    if (to_bcd(m_cnt) == lim) begin
`ifdef BCD_CNT_AUTORELOAD_EN
                        m_cnt = 0; m_done_p = 1;
`else
                        m_state = S_DONE;
`endif
                    end
                end else begin
                    m_pre++;
                end
            end
            if (acc && op == 2'd1 && (st0 == S_IDLE || st0 == S_PAUSE)) m_state = S_RUN;
        end
        m_drop = lap && sv0 && !sr;
        if (lap && (!sv0 || sr)) begin
            m_sd = to_bcd(c0); m_sv = 1;
        end else if (sv0 && sr) begin
            m_sv = 0;
        end
        m_ready = !acc;
    endtask

    task automatic push_exp();
        exp_t e;
        e.ready = m_ready;
        e.cnt   = to_bcd(m_cnt);
        e.run   = (m_state == S_RUN);
`ifdef BCD_CNT_AUTORELOAD_EN
        e.dn    = m_done_p;
`else
        e.dn    = (m_state == S_DONE);
`endif
        e.wr    = m_wrap;
        e.sv    = m_sv;
        e.sd    = m_sd;
        e.drop  = m_drop;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("cmd_ready",  16'(cmd_ready),  16'(mon_e.ready));
            chk("count",      16'(count),      16'(mon_e.cnt));
            chk("running",    16'(running),    16'(mon_e.run));
            chk("done",       16'(done),       16'(mon_e.dn));
            chk("wrap",       16'(wrap),       16'(mon_e.wr));
            chk("snap_valid", 16'(snap_valid), 16'(mon_e.sv));
            chk("snap_data",  16'(snap_data),  16'(mon_e.sd));
            chk("lap_drop",   16'(lap_drop),   16'(mon_e.drop));
        end
    end

    task automatic step(input bit v, input bit [1:0] op, input bit lap, input bit sr);
        cmd_valid = v; cmd_op = op; lap_req = lap; snap_ready = sr; limit = cur_lim;
        @(posedge clk);
        #1;
        model_edge(v, op, lap, sr, cur_lim);
        push_exp();
    endtask

    task automatic cmd(input bit [1:0] op);
        if (!m_ready) step(0, 2'd0, 0, 1);
        step(1, op, 0, 1);
    endtask

    task automatic run_until_cnt(input int target, input bit sr, input string name);
        int k;
        k = 0;
        while (!(m_cnt == target && m_ready) && k < 400) begin
            step(0, 2'd0, 0, sr);
            k++;
        end
        chk(name, 16'(m_cnt == target), 16'd1);
    endtask

    task automatic reset_mid();
        #2 clear = 1'b0;
        #1;
        chk("async_count",   16'(count),      16'd0);
        chk("async_running", 16'(running),    16'd0);
        chk("async_done",    16'(done),       16'd0);
        chk("async_wrap",    16'(wrap),       16'd0);
        chk("async_sv",      16'(snap_valid), 16'd0);
        chk("async_sd",      16'(snap_data),  16'd0);
        chk("async_drop",    16'(lap_drop),   16'd0);
        chk("async_ready",   16'(cmd_ready),  16'd1);
        exp_q.delete();
        model_reset();
        @(posedge clk);
        #1;
        push_exp();
        clear = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        logic [W-1:0] lims [6];
        clear = 1'b0;
        cur_lim = 8'h15;
        model_reset();
        push_exp();
        #12 clear = 1'b1;

        // Run to terminal value 15.
        cmd(2'd1);
        repeat (40) step(0, 2'd0, 0, 1);

        // Pause at 07 and resume.
        cur_lim = 8'hFA;
        cmd(2'd3);
        cmd(2'd1);
        run_until_cnt(7, 1, "reach_07");
        step(1, 2'd2, 0, 1);
        repeat (10) step(0, 2'd0, 0, 1);
        cmd(2'd1);
        repeat (6) step(0, 2'd0, 0, 1);

        // Wrap through 99 with an unmatchable limit.
        run_until_cnt(98, 1, "reach_98");
        repeat (6) step(0, 2'd0, 0, 1);

        // Lap capture then dropped lap.
        cmd(2'd3);
        cmd(2'd1);
        run_until_cnt(3, 0, "reach_03");
        step(0, 2'd0, 1, 0);
        run_until_cnt(5, 0, "reach_05");
        step(0, 2'd0, 1, 0);
        repeat (3) step(0, 2'd0, 0, 1);

        // ZERO on the tick edge at 09.
        k = 0;
        while (!(m_cnt == 9 && m_pre == PRESCALE - 1 && m_state == S_RUN && m_ready) && k < 400) begin
            step(0, 2'd0, 0, 1);
            k++;
        end
        chk("reach_09_tick", 16'(m_cnt), 16'd9);
        step(1, 2'd3, 0, 1);
        repeat (3) step(0, 2'd0, 0, 1);

        // Async clear mid-run with a pending snapshot.
        cur_lim = 8'h03;
        cmd(2'd1);
        repeat (3) step(0, 2'd0, 0, 1);
        step(0, 2'd0, 1, 0);
        step(0, 2'd0, 0, 0);
        reset_mid();
        repeat (20) begin
            cmd(2'd1);
            step(0, 2'd0, 0, 1);
        end

        lims[0] = 8'h15; lims[1] = 8'h03; lims[2] = 8'h00;
        lims[3] = 8'h42; lims[4] = 8'hFA; lims[5] = 8'($urandom);
        for (int p = 0; p < 6; p++) begin
            cur_lim = lims[p];
            for (int i = 0; i < 500; i++) begin
                bit [3:0] r;
                bit [1:0] op;
                r = 4'($urandom);
                op = (r < 8) ? 2'd1 : (r < 12) ? 2'd2 : (r < 15) ? 2'd0 : 2'd3;
                step(($urandom % 8) == 0, op, ($urandom % 6) == 0, ($urandom % 3) != 0);
            end
        end

        @(negedge clk);
        #1;
        chk("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_count_ctrl.md
Name: bcd_count_ctrl

Overview:
- Sequencer for a chain of cascaded mod-10 (BCD) digit counters, used for timer/stopwatch functions.
- Accepts start/stop/reset commands over a valid/ready handshake and prescales clk into count ticks.
- Stops at a programmable BCD terminal value; captures lap snapshots into a held output register.
- All counter state is synchronous to clk; the only asynchronous path is the active-low clear.

Parameters:
- DIGITS, 4: number of cascaded BCD digits; count width is 4*DIGITS.
- PRESCALE, 10: clk cycles per count tick; legal range 1..1023.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clear  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  controller can accept a command.
- cmd_op  input  2  command code: 00 NOP, 01 START, 10 STOP, 11 ZERO.
- limit  input  4*DIGITS  BCD terminal value, sampled on every tick.
- count  output  4*DIGITS  current BCD count, digit 0 in bits [3:0].
- running  output  1  high in RUN.
- done  output  1  high in DONE.
- wrap  output  1  one-cycle pulse when the count rolls over from all-9s to 0.
- lap_req  input  1  single-cycle request to snapshot the count.
- snap_valid  output  1  snapshot held in snap_data.
- snap_ready  input  1  consumer accepts the snapshot.
- snap_data  output  4*DIGITS  captured count.
- lap_drop  output  1  one-cycle pulse when a lap_req is lost.

Behaviour:
- Reset (clear=0, asynchronous):
  - state=IDLE, count=0, prescaler=0.
  - running=0, done=0, wrap=0, snap_valid=0, snap_data=0, lap_drop=0, cmd_ready=1.
- Command handshake:
  - A command is accepted on a rising edge with cmd_valid && cmd_ready.
  - cmd_ready is 0 for the cycle after an acceptance, then 1 again.
  - The accepted command takes effect at the accepting edge.
- States: IDLE, RUN, PAUSE, DONE.
  - START: IDLE→RUN; PAUSE→RUN. Prescaler is not cleared, so the partial tick is kept. No effect in RUN or DONE.
  - STOP: RUN→PAUSE. No effect elsewhere.
  - ZERO: from any state, count=0, prescaler=0, next state IDLE.
  - NOP: no effect.
- Ticks:
  - In RUN, the prescaler counts 0..PRESCALE-1. A tick occurs on the cycle it equals PRESCALE-1; the prescaler then returns to 0.
  - First tick occurs PRESCALE cycles after entry to RUN from zero.
- Count arithmetic on a tick:
  - Digit 0 increments mod 10.
  - Digit i increments only when digits 0..i-1 are all 9 (full ripple in one cycle).
  - Digits are never outside 0..9.
- Terminal value:
  - If the post-increment count equals limit, state goes to DONE at the same edge and the prescaler freezes.
  - A limit containing any nibble above 9 never matches.
  - limit=0 matches only after a full wrap.
- Wrap: an all-9s→0 tick asserts wrap for one cycle. Counting continues unless 0 equals limit.
- Simultaneous events:
  - ZERO beats a same-cycle tick: count=0 and no wrap.
  - STOP beats a same-cycle tick: the tick is discarded.
- Lap snapshot:
  - lap_req with snap_valid=0: snap_data←count (pre-tick value of that cycle); snap_valid=1 next cycle.
  - snap_valid stays 1 until snap_valid && snap_ready at an edge clears it.
  - lap_req while snap_valid=1 and not being accepted that cycle: request dropped, lap_drop pulses once.
  - lap_req in the same cycle as an acceptance: new capture, snap_valid stays 1.
  - lap_req is honoured in every state.
- Reset mid-operation: all outputs return to their reset values asynchronously, including a pending snapshot.

Optional Feature:
- Macro: BCD_CNT_AUTORELOAD_EN.
- Defined:
  - On a terminal match, count←0 and state stays RUN.
  - done pulses for one cycle only.
  - The prescaler continues without freezing.
- Undefined: DONE is sticky until ZERO. done stays high and count holds the limit value.

Decomposition:
- Shared package bcd_ctrl_pkg:
  - state enum: IDLE=0, RUN=1, PAUSE=2, DONE=3.
  - cmd_op constants: OP_NOP, OP_START, OP_STOP, OP_ZERO.
  - DIGIT_W=4, DIGIT_MAX=9.
- Sub-module bcd_digit:
  - One mod-10 digit with inputs inc and sync zero, outputs q[3:0] and carry (q==9 && inc).
  - Instantiated DIGITS times in a generate chain.

Test Plan (DIGITS=2, PRESCALE=2):
- Reset, then START with limit=8'h15 → running=1; count=8'h01 after 2 cycles; count reaches 8'h15, then done=1, running=0, count holds 8'h15.
- START, then STOP at count=8'h07, wait 10 cycles, START → count stays 8'h07 while paused and resumes to 8'h08 on the next tick.
- limit=8'hFA, run from 8'h98 → count goes 8'h99 then 8'h00, wrap pulses once, running stays 1.
- lap_req at count=8'h03 with snap_ready=0, then lap_req at 8'h05 → snap_data=8'h03, lap_drop pulses once; snap_ready=1 then clears snap_valid.
- ZERO issued in the same cycle as a tick at count=8'h09 → count=8'h00, no wrap, state IDLE; cmd_ready=0 for exactly one cycle.
- clear asserted mid-RUN with snap_valid=1 → all outputs reach reset values before the next edge; build with BCD_CNT_AUTORELOAD_EN, limit=8'h03 → done one-cycle pulse, count restarts from 8'h00, running stays 1.
